ex_muldiv: RTL
==============

# ex_muldiv

Iterative RV32M multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register. It consumes the operands and funct3 of an M-extension instruction held in ID/EX. It raises the stall that freezes IF/ID and ID/EX (the `stall2` input of the ID/EX register) until a 32-bit result is ready for the EX/MEM register. It uses one shift-add/restoring datapath shared by all eight M operations.

## Interface
- `XLEN`, 32: operand and result width; only 32 is supported.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: EX holds a valid M instruction (opcode 0110011, funct7 0000001).
- `flush` in 1: branch/jump squash of the EX instruction.
- `funct3` in 3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op_a` in 32: rs1 value after forwarding.
- `op_b` in 32: rs2 value after forwarding.
- `stall` out 1: hold IF/ID and ID/EX; wired to `stall2`.
- `done` out 1: `result` is valid this cycle.
- `result` out 32: final rd value.

## Operation
- States:
  - IDLE: no operation in progress.
  - BUSY: 32 iterations, tracked by a 6-bit counter.
  - DONE: one cycle with the result presented.
- IDLE:
  - `start && !flush` captures funct3, the operand signs and the absolute operand values.
  - Normal case goes to BUSY with counter = 0.
  - Special case goes directly to DONE with a fixed result.
- Special cases (divide ops only):
  - Divide by zero: DIV/DIVU return 0xFFFFFFFF; REM/REMU return `op_a`.
  - DIV/REM with `op_a` = 0x80000000 and `op_b` = 0xFFFFFFFF: DIV returns 0x80000000, REM returns 0.
- BUSY, multiply: one shift-add step per cycle into a 64-bit accumulator.
  - Operands are magnitudes.
  - Operand sign is honoured for MULH (both operands) and MULHSU (`op_a` only).
  - Product is negated at the end if the signs differ.
  - MUL returns bits [31:0]; MULH/MULHSU/MULHU return bits [63:32].
- BUSY, divide: one restoring step per cycle (33-bit remainder, 32-bit quotient), operating on magnitudes.
  - Quotient is negated if DIV and the operand signs differ.
  - Remainder takes the sign of the dividend for REM.
  - DIVU/REMU are unsigned throughout.
- BUSY exits to DONE when counter = 31; sign correction is applied on that transition.
- DONE: `done` = 1 and `result` is held. The state returns to IDLE next cycle. `start` is ignored in DONE, because it is still the same instruction leaving EX.
- `flush` in any state: next state is IDLE, and `done` is not asserted for the squashed operation. `flush` has priority over `start`.
- All arithmetic is modulo 2^32 on output; negation is two's complement.

## Timing
- `stall` = (IDLE && `start` && !`flush`) || BUSY. It is combinational, so it is high in the same cycle `start` first appears.
- Normal latency:
  - `start` seen in cycle 0.
  - BUSY in cycles 1–32.
  - DONE in cycle 33.
  - `stall` high in cycles 0–32 (33 cycles) and low in cycle 33, so ID/EX advances at the end of cycle 33.
- Special-case latency: `stall` high in cycle 0 only; DONE in cycle 1.
- Back-to-back M ops: the second instruction arrives while the state is IDLE (cycle 34) and is accepted without a bubble.
- Reset values: state = IDLE, counter = 0, `stall` = 0, `done` = 0, `result` = 0. All internal registers are cleared.
- Reset asserted mid-operation: IDLE immediately, and the result is discarded.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - MUL/MULH/MULHSU/MULHU use a single-cycle 33x33 signed multiplier.
  - IDLE → DONE directly, with `stall` high for cycle 0 only; `result` is valid in cycle 1.
  - Divide operations are unchanged.
- Undefined: all multiplies use the iterative 32-cycle path described above.

## Structure
- Package `muldiv_pkg` holds:
  - the funct3 encodings as localparams (`F3_MUL` … `F3_REMU`);
  - the state enum `muldiv_state_t` {IDLE, BUSY, DONE};
  - the special-case constants `DIV_ZERO_Q` = 0xFFFFFFFF and `INT_MIN` = 0x80000000.
- No sub-module. The shared accumulator/shift datapath and the FSM stay in one module.

## Test plan
- MUL `op_a` = 7, `op_b` = 0xFFFFFFFD → `result` 0xFFFFFFEB. `stall` high exactly 33 cycles; `done` in cycle 33.
- Multiply high variants:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- Signed divide of 0xFFFFFFF9 (−7) by 2:
  - DIV → 0xFFFFFFFD.
  - REM → 0xFFFFFFFF.
  - DIVU → 0x7FFFFFFC.
- Divide by zero:
  - DIV 5/0 → 0xFFFFFFFF.
  - REMU 5/0 → 5.
  - `stall` high 1 cycle; `done` in cycle 1.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0; 1-cycle stall.
- Flush and reset:
  - `flush` in BUSY cycle 10 → IDLE next cycle, `stall` low, no `done`.
  - Reset pulse mid-BUSY → all outputs 0.
  - A fresh DIVU 100/7 afterwards → 14.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings, FSM state type and special-case constants for the
// iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int XLEN_C = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN    = 32'h8000_0000;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} muldiv_state_t;

  // funct3[2] separates the divide family from the multiply family.
  function automatic logic is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

endpackage

// File: rtl/ex_muldiv.sv
// EX-stage RV32M unit: one shift-add / restoring-divide datapath, 32 cycles.
// Optional MULDIV_FAST_MUL_EN gives single-cycle multiplies.
module ex_muldiv
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  muldiv_state_t     state_q;
  logic [5:0]        cnt_q;
  logic [2:0]        f3_q;
  logic              sa_q, sb_q;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   b_q;
  logic [XLEN-1:0]   result_q;
  logic              done_q;

  // Operand signedness by operation; MUL low bits are sign-agnostic.
  logic a_signed, b_signed, sa, sb;
  logic [XLEN-1:0] abs_a, abs_b;
  assign a_signed = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                    (funct3 == F3_DIV)  || (funct3 == F3_REM);
  assign b_signed = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
  assign sa    = a_signed & op_a[XLEN-1];
  assign sb    = b_signed & op_b[XLEN-1];
  assign abs_a = sa ? (~op_a + 1'b1) : op_a;
  assign abs_b = sb ? (~op_b + 1'b1) : op_b;

  logic div_zero, div_ovf, special;
  logic [XLEN-1:0] special_res;
  assign div_zero = is_div(funct3) && (op_b == '0);
  assign div_ovf  = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                    (op_a == INT_MIN) && (op_b == '1);
  assign special  = div_zero || div_ovf;
  always_comb begin
    special_res = '0;
    if (div_zero)     special_res = funct3[1] ? op_a : DIV_ZERO_Q;
    else if (div_ovf) special_res = funct3[1] ? '0   : INT_MIN;
  end

  // Multiply step: conditional add into the high half, then shift right.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_nxt;
  assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
  assign mul_nxt = {mul_sum, acc_q[XLEN-1:1]};

  // Divide step: shift remainder:quotient left, trial-subtract the divisor.
  logic [XLEN:0]     rem_sh;
  logic [XLEN+1:0]   diff;
  logic              qbit;
  logic [XLEN-1:0]   new_rem;
  logic [2*XLEN-1:0] div_nxt;
  logic              unused_diff;
  assign rem_sh      = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign diff        = {1'b0, rem_sh} - {2'b00, b_q};
  assign qbit        = ~diff[XLEN+1];
  assign new_rem     = qbit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
  assign div_nxt     = {new_rem, acc_q[XLEN-2:0], qbit};
  assign unused_diff = diff[XLEN];

  logic [2*XLEN-1:0] acc_nxt, prod;
  logic [XLEN-1:0]   quo, rem, final_res;
  assign acc_nxt = is_div(f3_q) ? div_nxt : mul_nxt;

  always_comb begin
    prod = (sa_q ^ sb_q) ? (~acc_nxt + 1'b1) : acc_nxt;
    quo  = acc_nxt[XLEN-1:0];
    rem  = acc_nxt[2*XLEN-1:XLEN];
    if ((f3_q == F3_DIV) && (sa_q ^ sb_q)) quo = ~quo + 1'b1;
    if ((f3_q == F3_REM) && sa_q)          rem = ~rem + 1'b1;
    case (f3_q)
      F3_MUL:                        final_res = prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:  final_res = prod[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:               final_res = quo;
      default:                       final_res = rem;
    endcase
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [2*XLEN+1:0] fast_p;
  logic [XLEN-1:0]          fast_res;
  logic                     unused_fast;
  assign fast_p      = $signed({sa, op_a}) * $signed({sb, op_b});
  assign fast_res    = (funct3 == F3_MUL) ? fast_p[XLEN-1:0] : fast_p[2*XLEN-1:XLEN];
  assign unused_fast = ^fast_p[2*XLEN+1:2*XLEN];
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      acc_q    <= '0;
      b_q      <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start && !flush) begin
            f3_q  <= funct3;
            sa_q  <= sa;
            sb_q  <= sb;
            cnt_q <= '0;
            if (special) begin
              result_q <= special_res;
              done_q   <= 1'b1;
              state_q  <= DONE;
`ifdef MULDIV_FAST_MUL_EN
            end else if (!is_div(funct3)) begin
              result_q <= fast_res;
              done_q   <= 1'b1;
              state_q  <= DONE;
`endif
            end else begin
              // Low half holds the multiplier or the dividend; same layout.
              acc_q   <= {{XLEN{1'b0}}, abs_a};
              b_q     <= abs_b;
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          if (flush) begin
            state_q <= IDLE;
          end else begin
            acc_q <= acc_nxt;
            cnt_q <= cnt_q + 6'd1;
            if (cnt_q == 6'd31) begin
              result_q <= final_res;
              done_q   <= 1'b1;
              state_q  <= DONE;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign stall  = ((state_q == IDLE) && start && !flush) || (state_q == BUSY);
  // A squash arriving in the DONE cycle must not let the result retire.
  assign done   = done_q & ~flush;
  assign result = result_q;

endmodule
